// File: rtl/kerygma_mem_arb.sv
// kerygma_mem_arb
//   N-master to 1-slave arbiter for the MemSplit32 split-transaction bus.
//   The command phase (req/ack) is passed through combinationally from the
//   granted master to the slave. Read responses come back in order. Each
//   accepted read pushes its master index into an ID FIFO. Each slave
//   response pops the FIFO head and steers the response valid to that master.
//
//   Arbitration is round-robin by default. If KERYGMA_MEM_ARB_FIXED_PRIO_EN
//   is defined, fixed priority is used instead (master 0 is highest) and the
//   round-robin pointer is removed.
//
//   When a request is driven but not acked, the grant locks onto that master
//   until the request is accepted.
//
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   m_req_i / m_ack_o              per-master command handshake
//   m_addr_i, m_we_i, m_wdata_i,   per-master command fields
//   m_be_i                         (master k occupies slice k)
//   m_resp_o, m_rdata_o            per-master read response; the data is
//                                  broadcast and only m_resp_o qualifies it
//   s_req_o / s_ack_i              slave command handshake
//   s_addr_o, s_we_o, s_wdata_o,   slave command fields (from the granted master)
//   s_be_o
//   s_resp_i, s_rdata_i            slave read response
//   err_o                          sticky: a response arrived with no read
//                                  outstanding
module kerygma_mem_arb #(
  parameter int N_MASTERS = 2,
  parameter int RD_DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_MASTERS-1:0]   m_req_i,
  output logic [N_MASTERS-1:0]   m_ack_o,
  input  logic [N_MASTERS*32-1:0] m_addr_i,
  input  logic [N_MASTERS-1:0]   m_we_i,
  input  logic [N_MASTERS*32-1:0] m_wdata_i,
  input  logic [N_MASTERS*4-1:0] m_be_i,
  output logic [N_MASTERS-1:0]   m_resp_o,
  output logic [N_MASTERS*32-1:0] m_rdata_o,
  output logic                   s_req_o,
  input  logic                   s_ack_i,
  output logic [31:0]            s_addr_o,
  output logic                   s_we_o,
  output logic [31:0]            s_wdata_o,
  output logic [3:0]             s_be_o,
  input  logic                   s_resp_i,
  input  logic [31:0]            s_rdata_i,
  output logic                   err_o
);

  localparam int IDW = $clog2(N_MASTERS);
  localparam int PW  = $clog2(RD_DEPTH);
  localparam int CW  = PW + 1;

  logic [IDW-1:0] grant;
  logic [IDW-1:0] lock_id;
  logic           lock;
  logic [IDW-1:0] id_mem [RD_DEPTH];
  logic [IDW-1:0] head_id;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
  logic           grant_we;
  logic           blk;
  logic           req_int;
  logic           accept;
  logic           push;
  logic           pop;

`ifndef KERYGMA_MEM_ARB_FIXED_PRIO_EN
  logic [IDW-1:0] rr_ptr;
`endif

  // Grant selection. The loop runs from the far end back toward the start
  // point, so the last match is the nearest requester.
  always_comb begin
    grant = lock_id;
    if (!lock) begin
`ifdef KERYGMA_MEM_ARB_FIXED_PRIO_EN
      grant = '0;
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
        if (m_req_i[i]) grant = IDW'(i);
      end
`else
      grant = rr_ptr;
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
        if (m_req_i[(int'(rr_ptr) + i) % N_MASTERS])
          grant = IDW'((int'(rr_ptr) + i) % N_MASTERS);
      end
`endif
    end
  end

  assign full     = (count == CW'(RD_DEPTH));
  assign empty    = (count == '0);
  assign grant_we = m_we_i[grant];

  // A full FIFO blocks any new grant. It also holds back a locked read, which
  // has no FIFO slot to land in. A locked write has no such dependency, so it
  // stays driven.
  assign blk      = full & (~lock | ~grant_we);
  assign req_int  = m_req_i[grant] & ~blk;
  assign accept   = req_int & s_ack_i;
  assign push     = accept & ~grant_we;
  assign pop      = s_resp_i & ~empty;
  assign head_id  = id_mem[rd_ptr];

  // Outputs are forced to zero while reset is asserted, including the
  // combinational pass-throughs.
  assign s_req_o   = rst_ni & req_int;
  assign s_addr_o  = rst_ni ? m_addr_i[int'(grant)*32 +: 32]  : '0;
  assign s_wdata_o = rst_ni ? m_wdata_i[int'(grant)*32 +: 32] : '0;
  assign s_be_o    = rst_ni ? m_be_i[int'(grant)*4 +: 4]      : '0;
  assign s_we_o    = rst_ni & grant_we;
  assign m_rdata_o = rst_ni ? {N_MASTERS{s_rdata_i}} : '0;

  always_comb begin
    m_ack_o = '0;
    if (rst_ni && accept) m_ack_o[grant] = 1'b1;
  end

  always_comb begin
    m_resp_o = '0;
    if (rst_ni && pop) m_resp_o[head_id] = 1'b1;
  end

  // Control state: lock, FIFO pointers and count, sticky error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock    <= 1'b0;
      lock_id <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_o   <= 1'b0;
    end else begin
      if (accept) begin
        lock <= 1'b0;
      end else if (req_int) begin
        lock    <= 1'b1;
        lock_id <= grant;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (s_resp_i && empty) err_o <= 1'b1;
    end
  end

`ifndef KERYGMA_MEM_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (int'(grant) == N_MASTERS - 1) ? '0 : grant + 1'b1;
    end
  end
`endif

  // ID storage holds data only, so it has no reset.
  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_kerygma_mem_arb.sv
module tb_kerygma_mem_arb;

  localparam int N = 3;
  localparam int D = 4;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    m_req_i;
  logic [N-1:0]    m_ack_o;
  logic [N*32-1:0] m_addr_i;
  logic [N-1:0]    m_we_i;
  logic [N*32-1:0] m_wdata_i;
  logic [N*4-1:0]  m_be_i;
  logic [N-1:0]    m_resp_o;
  logic [N*32-1:0] m_rdata_o;
  logic            s_req_o;
  logic            s_ack_i;
  logic [31:0]     s_addr_o;
  logic            s_we_o;
  logic [31:0]     s_wdata_o;
  logic [3:0]      s_be_o;
  logic            s_resp_i;
  logic [31:0]     s_rdata_i;
  logic            err_o;

  kerygma_mem_arb #(.N_MASTERS(N), .RD_DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_ack_o(m_ack_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
    .m_wdata_i(m_wdata_i), .m_be_i(m_be_i), .m_resp_o(m_resp_o), .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_ack_i(s_ack_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_wdata_o(s_wdata_o), .s_be_o(s_be_o), .s_resp_i(s_resp_i), .s_rdata_i(s_rdata_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: arbitration state kept as plain integers and a queue
  int           rr;
  bit           locked;
  int           lock_id;
  int           q[$];
  bit           merr;
  logic [N-1:0] ack_prev;

  always @(negedge clk) begin
    int g;
    bit full, sreq, acc, popv;
    logic [N-1:0] e_ack, e_resp;
    if (!rst_ni) begin
      check("rst_s_req", {63'd0, s_req_o}, 64'd0);
      check("rst_ack", {61'd0, m_ack_o}, 64'd0);
      check("rst_resp", {61'd0, m_resp_o}, 64'd0);
      check("rst_err", {63'd0, err_o}, 64'd0);
      check("rst_rdata", {32'd0, m_rdata_o[31:0]}, 64'd0);
      rr = 0; locked = 0; lock_id = 0; q.delete(); merr = 0; ack_prev = '0;
    end else begin
      g = -1;
      if (locked) g = lock_id;
      else begin
        for (int k = 0; k < N; k++) begin
`ifdef KERYGMA_MEM_ARB_FIXED_PRIO_EN
          if (g < 0 && m_req_i[k]) g = k;
`else
          if (g < 0 && m_req_i[(rr + k) % N]) g = (rr + k) % N;
`endif
        end
      end
      full = (q.size() == D);
      sreq = (g >= 0) && m_req_i[g] && (!full || (locked && m_we_i[g]));
      acc  = sreq && s_ack_i;
      e_ack = '0;
      if (acc) e_ack[g] = 1'b1;
      popv = s_resp_i && (q.size() > 0);
      e_resp = '0;
      if (popv) e_resp[q[0]] = 1'b1;

      check("m_s_req", {63'd0, s_req_o}, {63'd0, sreq});
      check("m_ack", {61'd0, m_ack_o}, {61'd0, e_ack});
      check("m_resp", {61'd0, m_resp_o}, {61'd0, e_resp});
      check("m_err", {63'd0, err_o}, {63'd0, merr});
      if (sreq) begin
        check("m_s_addr", {32'd0, s_addr_o}, {32'd0, m_addr_i[g*32 +: 32]});
        check("m_s_fields", {27'd0, s_we_o, s_be_o, s_wdata_o},
              {27'd0, m_we_i[g], m_be_i[g*4 +: 4], m_wdata_i[g*32 +: 32]});
      end
      if (popv) check("m_rdata", {32'd0, m_rdata_o[q[0]*32 +: 32]}, {32'd0, s_rdata_i});

      if (s_resp_i && q.size() == 0) merr = 1;
      if (popv) void'(q.pop_front());
      if (acc) begin
        rr = (g + 1) % N;
        locked = 0;
        if (!m_we_i[g]) q.push_back(g);
      end else if (sreq) begin
        locked = 1;
        lock_id = g;
      end
      ack_prev = e_ack;
    end
  end

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic req_set(input int m, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    m_req_i[m] = 1'b1;
    m_we_i[m]  = we;
    m_addr_i[m*32 +: 32]  = a;
    m_wdata_i[m*32 +: 32] = d;
    m_be_i[m*4 +: 4]      = be;
  endtask

  initial begin
    rst_ni = 1'b0;
    m_req_i = 3'b011; m_we_i = '0; m_addr_i = '0; m_wdata_i = '0; m_be_i = '0;
    s_ack_i = 1'b1; s_resp_i = 1'b1; s_rdata_i = 32'h5555_5555;
    @(negedge clk); adv();
    @(negedge clk); adv();
    m_req_i = '0; s_ack_i = 1'b0; s_resp_i = 1'b0;
    rst_ni = 1'b1;

    // Two masters stream reads, round-robin alternates
    req_set(0, 0, 32'h10, 0, 4'hF); req_set(1, 0, 32'h14, 0, 4'hF); s_ack_i = 1'b1;
    @(negedge clk); check("t1_ack_a", {61'd0, m_ack_o}, 64'b001); adv();
    @(negedge clk); check("t1_ack_b", {61'd0, m_ack_o}, 64'b010); adv();
    @(negedge clk); check("t1_ack_c", {61'd0, m_ack_o}, 64'b001); adv();
    m_req_i = '0; s_ack_i = 1'b0; s_resp_i = 1'b1;
    @(negedge clk); check("t1_id0", {61'd0, m_resp_o}, 64'b001); adv();
    @(negedge clk); check("t1_id1", {61'd0, m_resp_o}, 64'b010); adv();
    @(negedge clk); check("t1_id2", {61'd0, m_resp_o}, 64'b001); adv();
    s_resp_i = 1'b0;

    // Lock: m1 stalled, m0 arrives meanwhile
    req_set(1, 0, 32'h20, 0, 4'hF);
    @(negedge clk); check("t2_sreq", {63'd0, s_req_o}, 64'd1);
    check("t2_noack", {61'd0, m_ack_o}, 64'd0); adv();
    req_set(0, 0, 32'h30, 0, 4'hF);
    @(negedge clk); check("t2_hold_addr", {32'd0, s_addr_o}, 64'h20); adv();
    @(negedge clk); check("t2_hold_ack", {61'd0, m_ack_o}, 64'd0); adv();
    s_ack_i = 1'b1;
    @(negedge clk); check("t2_ack_m1", {61'd0, m_ack_o}, 64'b010); adv();
    m_req_i[1] = 1'b0;
    @(negedge clk); check("t2_ack_m0", {61'd0, m_ack_o}, 64'b001);
    check("t2_addr_m0", {32'd0, s_addr_o}, 64'h30); adv();
    m_req_i = '0; s_ack_i = 1'b0; s_resp_i = 1'b1;
    @(negedge clk); check("t2_r1", {61'd0, m_resp_o}, 64'b010); adv();
    @(negedge clk); check("t2_r0", {61'd0, m_resp_o}, 64'b001); adv();
    s_resp_i = 1'b0;

    // FIFO full blocks the fifth read until a response frees a slot
    req_set(0, 0, 32'h40, 0, 4'hF); s_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("t3_fill", {61'd0, m_ack_o}, 64'b001); adv();
    end
    @(negedge clk); check("t3_blk", {63'd0, s_req_o}, 64'd0);
    check("t3_blk_ack", {61'd0, m_ack_o}, 64'd0); adv();
    s_resp_i = 1'b1; s_rdata_i = 32'h1234;
    @(negedge clk); check("t3_resp", {61'd0, m_resp_o}, 64'b001);
    check("t3_blk_pop", {63'd0, s_req_o}, 64'd0); adv();
    s_resp_i = 1'b0;
    @(negedge clk); check("t3_fifth", {61'd0, m_ack_o}, 64'b001); adv();
    m_req_i = '0; s_ack_i = 1'b0; s_resp_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("t3_drain", {61'd0, m_resp_o}, 64'b001); adv();
    end
    s_resp_i = 1'b0;

    // Response routing with data
    req_set(0, 0, 32'h100, 0, 4'hF); s_ack_i = 1'b1;
    @(negedge clk); check("t4_addr0", {32'd0, s_addr_o}, 64'h100); adv();
    m_req_i[0] = 1'b0; req_set(1, 0, 32'h200, 0, 4'hF);
    @(negedge clk); check("t4_addr1", {32'd0, s_addr_o}, 64'h200);
    check("t4_ack1", {61'd0, m_ack_o}, 64'b010); adv();
    m_req_i = '0; s_ack_i = 1'b0; s_resp_i = 1'b1; s_rdata_i = 32'hAAAA;
    @(negedge clk); check("t4_resp0", {61'd0, m_resp_o}, 64'b001);
    check("t4_data0", {32'd0, m_rdata_o[31:0]}, 64'hAAAA); adv();
    s_rdata_i = 32'hBBBB;
    @(negedge clk); check("t4_resp1", {61'd0, m_resp_o}, 64'b010);
    check("t4_data1", {32'd0, m_rdata_o[63:32]}, 64'hBBBB); adv();
    s_resp_i = 1'b0;

    // Write forwarding, then an unsolicited response
    req_set(0, 1, 32'h300, 32'hDEAD_BEEF, 4'b0011); s_ack_i = 1'b1;
    @(negedge clk);
    check("t5_fields", {27'd0, s_we_o, s_be_o, s_wdata_o}, {27'd0, 1'b1, 4'b0011, 32'hDEAD_BEEF});
    check("t5_ack", {61'd0, m_ack_o}, 64'b001); adv();
    m_req_i = '0; m_we_i = '0; s_ack_i = 1'b0; s_resp_i = 1'b1;
    @(negedge clk); check("t5_noresp", {61'd0, m_resp_o}, 64'd0);
    check("t5_err_pre", {63'd0, err_o}, 64'd0); adv();
    s_resp_i = 1'b0;
    @(negedge clk); check("t5_err", {63'd0, err_o}, 64'd1); adv();

    // Reset mid-flight
    rst_ni = 1'b0; @(negedge clk); adv(); rst_ni = 1'b1;
    @(negedge clk); check("t6_err_clr", {63'd0, err_o}, 64'd0); adv();
    req_set(0, 0, 32'h500, 0, 4'hF); s_ack_i = 1'b1;
    @(negedge clk); check("t6_rd0", {61'd0, m_ack_o}, 64'b001); adv();
    m_req_i[0] = 1'b0; req_set(1, 0, 32'h504, 0, 4'hF);
    @(negedge clk); check("t6_rd1", {61'd0, m_ack_o}, 64'b010); adv();
    rst_ni = 1'b0; m_req_i = 3'b011; s_resp_i = 1'b1;
    @(negedge clk); check("t6_rst_sreq", {63'd0, s_req_o}, 64'd0);
    check("t6_rst_resp", {61'd0, m_resp_o}, 64'd0); adv();
    m_req_i = '0; s_ack_i = 1'b0; s_resp_i = 1'b0; rst_ni = 1'b1;
    @(negedge clk); check("t6_err0", {63'd0, err_o}, 64'd0); adv();
    s_resp_i = 1'b1;
    @(negedge clk); check("t6_drop", {61'd0, m_resp_o}, 64'd0); adv();
    s_resp_i = 1'b0;
    @(negedge clk); check("t6_err1", {63'd0, err_o}, 64'd1); adv();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_ni = !(c % 600 == 300);
      for (int m = 0; m < N; m++) begin
        if (m_req_i[m] && ack_prev[m]) m_req_i[m] = 1'b0;
        else if (!m_req_i[m] && $urandom_range(0, 2) == 0)
          req_set(m, $urandom_range(0, 2) == 0, $urandom, $urandom, 4'($urandom));
      end
      s_ack_i   = ($urandom_range(0, 3) != 0);
      s_resp_i  = (q.size() > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 199) == 0);
      s_rdata_i = $urandom;
      @(negedge clk); adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
